// File: rtl/rr_priority_pick.sv
// rr_priority_pick: one-hot and encoded pick of the first request at or after ptr, wrapping.
module rr_priority_pick #(
  parameter int N = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] idx
);
  logic [2*N-1:0] dbl;
  logic hit;
  int s;
  // Scan downward so the lowest rotated position is the last one written and wins.
  always_comb begin
    dbl = {req, req} >> ptr;
    hit = 1'b0;
    idx = '0;
    s = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (dbl[i]) begin
        hit = 1'b1;
        s = i + int'(ptr);
        idx = SW'(s >= N ? s - N : s);
      end
    end
  end
  assign grant = hit ? N'(1) << idx : '0;
endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin N:1 valid/ready mux with a single registered output stage.
module rr_mux_arbiter #(
  parameter int N = 4,
  parameter int W = 8,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_src
);
  logic [SW-1:0] ptr, idx;
  logic [N-1:0] grant;
  logic load;
  rr_priority_pick #(.N(N), .SW(SW)) u_pick (
    .req(in_valid),
    .ptr(ptr),
    .grant(grant),
    .idx(idx)
  );
  assign load = !out_valid || out_ready;
  assign in_ready = rst ? '0 : grant & {N{load}};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_src <= '0;
      ptr <= '0;
    end else if (load) begin
      out_valid <= |grant;
      if (|grant) begin
        out_data <= in_data[idx*W +: W];
        out_src <= idx;
        ptr <= (idx == SW'(N - 1)) ? '0 : idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed vector table, async-reset and round-robin sequences, random soak.
module tb_rr_mux_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int SW = 2;
  localparam logic [31:0] D = 32'h13121110;
  logic clk, rst, out_valid, out_ready;
  logic [N-1:0] in_valid, in_ready;
  logic [N*W-1:0] in_data;
  logic [W-1:0] out_data;
  logic [SW-1:0] out_src;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic rst;
    logic [3:0] v;
    logic [31:0] d;
    logic ordy;
    logic [3:0] e_rdy;
    logic e_ov;
    logic [7:0] e_od;
    logic [1:0] e_os;
  } vec_t;
  vec_t tv[17];
  rr_mux_arbiter #(.N(N), .W(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_src(out_src)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask
  // Bench-side model state for the soak.
  logic [1:0] m_ptr, m_src;
  logic m_valid;
  logic [7:0] m_data;
  logic [5:0] seq[N];
  logic [5:0] exp_seq[N];
  logic [N-1:0] acc, eg;
  int pushed, popped, c;
  initial begin
    rst = 1'b1;
    in_valid = '0;
    in_data = '0;
    out_ready = 1'b1;
    tv[0]  = '{1'b1, 4'b0000, 32'h0,        1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
    tv[1]  = '{1'b1, 4'b0000, 32'h0,        1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
    tv[2]  = '{1'b0, 4'b0100, 32'h00A50000, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
    tv[3]  = '{1'b0, 4'b0011, D,            1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    tv[4]  = '{1'b0, 4'b0011, D,            1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    tv[5]  = '{1'b0, 4'b0000, D,            1'b1, 4'b0000, 1'b0, 8'h11, 2'd1};
    tv[6]  = '{1'b0, 4'b1111, D,            1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    tv[7]  = '{1'b0, 4'b1111, D,            1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    tv[8]  = '{1'b0, 4'b1111, D,            1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    tv[9]  = '{1'b0, 4'b1111, D,            1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    tv[10] = '{1'b0, 4'b1111, D,            1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
    tv[11] = '{1'b0, 4'b1111, D,            1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
    tv[12] = '{1'b0, 4'b1111, D,            1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
    tv[13] = '{1'b0, 4'b1111, D,            1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    tv[14] = '{1'b0, 4'b0000, D,            1'b0, 4'b0000, 1'b1, 8'h12, 2'd2};
    tv[15] = '{1'b0, 4'b0000, D,            1'b1, 4'b0000, 1'b0, 8'h12, 2'd2};
    tv[16] = '{1'b0, 4'b0010, D,            1'b0, 4'b0010, 1'b1, 8'h11, 2'd1};
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      rst = tv[i].rst;
      in_valid = tv[i].v;
      in_data = tv[i].d;
      out_ready = tv[i].ordy;
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(tv[i].e_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tv[i].e_ov));
      chk($sformatf("v%0d out_data", i), 32'(out_data), 32'(tv[i].e_od));
      chk($sformatf("v%0d out_src", i), 32'(out_src), 32'(tv[i].e_os));
    end
    // Async reset while FULL: output must clear before any clock edge.
    @(negedge clk);
    in_valid = '0;
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async out_valid", 32'(out_valid), 32'd0);
    chk("async out_data", 32'(out_data), 32'd0);
    chk("async in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    in_valid = 4'b1111;
    in_data = D;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rr%0d out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("rr%0d out_src", i), 32'(out_src), i % 4);
      chk($sformatf("rr%0d out_data", i), 32'(out_data), 32'h10 + i % 4);
    end
    // Random soak from a fresh reset.
    @(negedge clk);
    rst = 1'b1;
    in_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    m_ptr = '0;
    m_valid = 1'b0;
    m_data = '0;
    m_src = '0;
    acc = '0;
    pushed = 0;
    popped = 0;
    for (int k = 0; k < N; k++) begin
      seq[k] = '0;
      exp_seq[k] = '0;
    end
    for (int t = 0; t < 10000; t++) begin
      for (int k = 0; k < N; k++) begin
        if (acc[k]) begin
          seq[k] = seq[k] + 1'b1;
          in_valid[k] = 1'b0;
        end
        if (!in_valid[k]) in_valid[k] = $urandom_range(0, 2) != 0;
        else if ($urandom_range(0, 15) == 0) in_valid[k] = 1'b0;
        in_data[k*W +: W] = {2'(k), seq[k]};
      end
      out_ready = $urandom_range(0, 3) != 0;
      #1;
      eg = '0;
      for (int j = N - 1; j >= 0; j--) begin
        c = (int'(m_ptr) + j) % N;
        if (in_valid[c]) eg = N'(1) << c;
      end
      if (m_valid && !out_ready) eg = '0;
      chk("soak in_ready", 32'(in_ready), 32'(eg));
      chk("soak onehot", 32'($countones(in_ready) <= 1), 32'd1);
      if (out_valid && out_ready) begin
        chk("soak order", 32'(out_data[5:0]), 32'(exp_seq[out_src]));
        exp_seq[out_src] = exp_seq[out_src] + 1'b1;
        popped++;
      end
      acc = in_valid & in_ready;
      pushed += $countones(acc);
      if (!m_valid || out_ready) begin
        m_valid = |eg;
        for (int k = 0; k < N; k++) begin
          if (eg[k]) begin
            m_data = in_data[k*W +: W];
            m_src = 2'(k);
            m_ptr = 2'((k + 1) % N);
          end
        end
      end
      @(posedge clk);
      #1;
      chk("soak out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("soak out_data", 32'(out_data), 32'(m_data));
        chk("soak out_src", 32'(out_src), 32'(m_src));
      end
      @(negedge clk);
    end
    in_valid = '0;
    out_ready = 1'b1;
    #1;
    if (out_valid) popped++;
    @(posedge clk);
    #1;
    chk("drain out_valid", 32'(out_valid), 32'd0);
    chk("push pop count", 32'(popped), 32'(pushed));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
